// File: rtl/ysyx_040750_mem_arbiter.sv
// ysyx_040750_mem_arbiter: shares one memory port between IF fetch and LSU, one transaction in flight.
// Define ARB_RR_EN for round-robin arbitration; the default build uses fixed LSU priority.
module ysyx_040750_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                I_sys_clk,
  input  logic                I_rst_n,
  input  logic                I_if_req_valid,
  input  logic [ADDR_W-1:0]   I_if_addr,
  output logic                O_if_req_ready,
  input  logic                I_if_flush,
  output logic                O_if_rsp_valid,
  output logic [31:0]         O_if_inst,
  input  logic                I_ls_req_valid,
  input  logic                I_ls_wen,
  input  logic [ADDR_W-1:0]   I_ls_addr,
  input  logic [DATA_W-1:0]   I_ls_wdata,
  input  logic [DATA_W/8-1:0] I_ls_wstrb,
  output logic                O_ls_req_ready,
  output logic                O_ls_rsp_valid,
  output logic [DATA_W-1:0]   O_ls_rdata,
  output logic                O_mem_req_valid,
  output logic                O_mem_wen,
  output logic [ADDR_W-1:0]   O_mem_addr,
  output logic [DATA_W-1:0]   O_mem_wdata,
  output logic [DATA_W/8-1:0] O_mem_wstrb,
  input  logic                I_mem_req_ready,
  input  logic                I_mem_rsp_valid,
  input  logic [DATA_W-1:0]   I_mem_rdata
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_RSP = 2'd2} state_e;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   drop_q, drop_d;
  logic   if_hi_q, if_hi_d;
  logic   ls_wen_q, ls_wen_d;
  logic   any_req_s, grant_s, grant_en_s;
  logic   in_req_s, in_rsp_s, own_ls_s, own_if_s, rsp_hit_s;

  assign any_req_s = I_if_req_valid | I_ls_req_valid;
  assign in_req_s  = (state_q == ST_REQ);
  assign in_rsp_s  = (state_q == ST_RSP);
  assign own_ls_s  = (owner_q == OWN_LS);
  assign own_if_s  = (owner_q == OWN_IF);
  assign rsp_hit_s = in_rsp_s & I_mem_rsp_valid;

`ifdef ARB_RR_EN
  logic last_q;

  // Round-robin: on a tie grant the master that did not win the previous arbitration.
  always_comb begin
    if (I_if_req_valid && I_ls_req_valid) begin
      grant_s = ~last_q;
    end else begin
      grant_s = I_ls_req_valid;
    end
  end

  // Remember the most recent winner.
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      last_q <= OWN_IF;
    end else if (grant_en_s) begin
      last_q <= grant_s;
    end
  end
`else
  // Fixed priority: a pending LSU request always wins.
  assign grant_s = I_ls_req_valid;
`endif

  // State and transaction-context registers.
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_IF;
      drop_q   <= 1'b0;
      if_hi_q  <= 1'b0;
      ls_wen_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      drop_q   <= drop_d;
      if_hi_q  <= if_hi_d;
      ls_wen_q <= ls_wen_d;
    end
  end

  // Next-state logic; a response with a request pending re-arbitrates without an idle bubble.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    drop_d     = drop_q;
    if_hi_d    = if_hi_q;
    ls_wen_d   = ls_wen_q;
    grant_en_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          owner_d    = grant_s;
          grant_en_s = 1'b1;
          state_d    = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (own_if_s && I_if_flush) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
        if (I_mem_req_ready) begin
          // Capture what the response path needs; masters may change payload after acceptance.
          if_hi_d  = I_if_addr[2];
          ls_wen_d = I_ls_wen;
          state_d  = ST_RSP;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RSP: begin
        if (I_mem_rsp_valid) begin
          drop_d = 1'b0;
          if (any_req_s) begin
            owner_d    = grant_s;
            grant_en_s = 1'b1;
            state_d    = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (own_if_s && I_if_flush) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        drop_d  = 1'b0;
      end
    endcase
  end

  // Memory-side request payload, muxed from the current owner only while requesting.
  always_comb begin
    O_mem_req_valid = in_req_s;
    O_mem_wen       = in_req_s & own_ls_s & I_ls_wen;
    O_mem_addr      = {ADDR_W{1'b0}};
    O_mem_wdata     = {DATA_W{1'b0}};
    O_mem_wstrb     = {(DATA_W/8){1'b0}};
    if (in_req_s && own_ls_s) begin
      O_mem_addr  = I_ls_addr;
      O_mem_wdata = I_ls_wdata;
      O_mem_wstrb = I_ls_wen ? I_ls_wstrb : {(DATA_W/8){1'b0}};
    end else if (in_req_s) begin
      O_mem_addr = I_if_addr;
    end else begin
      O_mem_addr = {ADDR_W{1'b0}};
    end
  end

  // Handshake and response routing back to the latched owner.
  always_comb begin
    O_if_req_ready = in_req_s & own_if_s & I_mem_req_ready;
    O_ls_req_ready = in_req_s & own_ls_s & I_mem_req_ready;
    O_if_rsp_valid = rsp_hit_s & own_if_s & ~drop_q & ~I_if_flush;
    O_ls_rsp_valid = rsp_hit_s & own_ls_s;
    if (O_if_rsp_valid) begin
      O_if_inst = if_hi_q ? I_mem_rdata[32 +: 32] : I_mem_rdata[0 +: 32];
    end else begin
      O_if_inst = 32'd0;
    end
    if (O_ls_rsp_valid && !ls_wen_q) begin
      O_ls_rdata = I_mem_rdata;
    end else begin
      O_ls_rdata = {DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_ysyx_040750_mem_arbiter.sv
// Bench for ysyx_040750_mem_arbiter: directed scenarios, then randomized traffic checked against a
// transaction-level model (owner / accepted / dropped). Define ARB_RR_EN to check round-robin.
module tb_ysyx_040750_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid, if_flush, ls_req_valid, ls_wen, mem_req_ready, mem_rsp_valid;
  logic [31:0] if_addr, ls_addr;
  logic [63:0] ls_wdata, mem_rdata;
  logic [7:0]  ls_wstrb;
  logic        o_if_req_ready, o_if_rsp_valid, o_ls_req_ready, o_ls_rsp_valid;
  logic        o_mem_req_valid, o_mem_wen;
  logic [31:0] o_if_inst, o_mem_addr;
  logic [63:0] o_ls_rdata, o_mem_wdata;
  logic [7:0]  o_mem_wstrb;

  int tests = 0;
  int fails = 0;

  ysyx_040750_mem_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
    .I_sys_clk(clk), .I_rst_n(rst_n),
    .I_if_req_valid(if_req_valid), .I_if_addr(if_addr), .O_if_req_ready(o_if_req_ready),
    .I_if_flush(if_flush), .O_if_rsp_valid(o_if_rsp_valid), .O_if_inst(o_if_inst),
    .I_ls_req_valid(ls_req_valid), .I_ls_wen(ls_wen), .I_ls_addr(ls_addr),
    .I_ls_wdata(ls_wdata), .I_ls_wstrb(ls_wstrb), .O_ls_req_ready(o_ls_req_ready),
    .O_ls_rsp_valid(o_ls_rsp_valid), .O_ls_rdata(o_ls_rdata),
    .O_mem_req_valid(o_mem_req_valid), .O_mem_wen(o_mem_wen), .O_mem_addr(o_mem_addr),
    .O_mem_wdata(o_mem_wdata), .O_mem_wstrb(o_mem_wstrb), .I_mem_req_ready(mem_req_ready),
    .I_mem_rsp_valid(mem_rsp_valid), .I_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req_valid = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
    ls_req_valid = 1'b0; ls_wen = 1'b0; ls_addr = 32'd0; ls_wdata = 64'd0; ls_wstrb = 8'd0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 64'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Arbitration rule: single requester wins; on a tie LSU (fixed) or the non-last master (RR).
  function automatic logic pick(input logic ifv, input logic lsv, input logic last);
`ifdef ARB_RR_EN
    if (ifv && lsv) return ~last;
`else
    if (ifv && lsv) return 1'b1;
`endif
    return lsv;
  endfunction

  // Randomized-run model state (1 = LSU for owner/last).
  bit          busy, own_ls, acc, dropped, last, acc_hi, acc_wen;
  bit          ifv, lsv, lswen, exp_req, deliver, hs;
  logic [31:0] ifa, lsa;
  logic [63:0] lswd, rd, wd;
  logic [7:0]  lsws;
  logic        win;
  int          hs_cnt;

  initial begin
    // Reset with junk on the inputs: every output must be 0.
    idle_inputs();
    if_req_valid = 1'b1; ls_req_valid = 1'b1; ls_wen = 1'b1; ls_wstrb = 8'hFF;
    if_addr = $urandom; ls_addr = $urandom; ls_wdata = {$urandom, $urandom};
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = {$urandom, $urandom};
    tick(); tick(); smp();
    chk("rst_mem_req", {63'd0, o_mem_req_valid}, 64'd0);
    chk("rst_ready", {62'd0, o_if_req_ready, o_ls_req_ready}, 64'd0);
    chk("rst_rsp", {62'd0, o_if_rsp_valid, o_ls_rsp_valid}, 64'd0);
    chk("rst_payload", {o_mem_addr, 23'd0, o_mem_wen, o_mem_wstrb}, 64'd0);
    chk("rst_wdata", o_mem_wdata, 64'd0);
    chk("rst_rdata", o_ls_rdata | {32'd0, o_if_inst}, 64'd0);

    // IF fetch, memory ready at once: instruction at cycle 2 from the upper word.
    do_reset();
    tick(); if_req_valid = 1'b1; if_addr = 32'h8000_0004; mem_req_ready = 1'b1;
    smp(); chk("t1_c0_no_req", {63'd0, o_mem_req_valid}, 64'd0);
    tick(); smp();
    chk("t1_c1_req", {63'd0, o_mem_req_valid}, 64'd1);
    chk("t1_c1_addr", {32'd0, o_mem_addr}, 64'h8000_0004);
    chk("t1_c1_rd", {55'd0, o_mem_wen, o_mem_wstrb}, 64'd0);
    chk("t1_c1_ready", {62'd0, o_if_req_ready, o_ls_req_ready}, 64'd2);
    tick(); if_req_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
    smp();
    chk("t1_c2_rsp", {62'd0, o_if_rsp_valid, o_ls_rsp_valid}, 64'd2);
    chk("t1_c2_inst", {32'd0, o_if_inst}, 64'h1111_2222);
    tick(); mem_rsp_valid = 1'b0; smp();
    chk("t1_c3_idle", {61'd0, o_mem_req_valid, o_if_rsp_valid, o_ls_rsp_valid}, 64'd0);

    // LSU store with memory ready delayed 3 cycles: payload holds, exactly one handshake.
    do_reset();
    wd = {$urandom, $urandom}; hs_cnt = 0;
    tick(); ls_req_valid = 1'b1; ls_wen = 1'b1; ls_addr = 32'h8000_1000; ls_wdata = wd;
    ls_wstrb = 8'hFF;
    smp(); chk("t2_c0_no_req", {63'd0, o_mem_req_valid}, 64'd0);
    for (int c = 1; c <= 4; c++) begin
      tick(); mem_req_ready = (c == 4);
      smp();
      chk("t2_req", {63'd0, o_mem_req_valid}, 64'd1);
      chk("t2_addr_wen_strb", {o_mem_addr, 23'd0, o_mem_wen, o_mem_wstrb}, {32'h8000_1000, 23'd0, 1'b1, 8'hFF});
      chk("t2_wdata", o_mem_wdata, wd);
      chk("t2_ready", {62'd0, o_if_req_ready, o_ls_req_ready}, {62'd0, 1'b0, c == 4});
      if (o_mem_req_valid && mem_req_ready) hs_cnt++;
    end
    tick(); ls_req_valid = 1'b0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
    mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    smp();
    if (o_mem_req_valid && mem_req_ready) hs_cnt++;
    chk("t2_handshakes", 64'(hs_cnt), 64'd1);
    chk("t2_ack", {62'd0, o_if_rsp_valid, o_ls_rsp_valid}, 64'd1);
    chk("t2_ack_rdata", o_ls_rdata, 64'd0);
    tick(); mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;

    // Simultaneous requests from idle, four times.
    do_reset();
    last = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(); if_req_valid = 1'b1; ls_req_valid = 1'b1; ls_wen = 1'b0; mem_req_ready = 1'b1;
      if_addr = 32'h8000_2000 + 32'(k * 8); ls_addr = 32'h9000_0000 + 32'(k * 8);
      win = pick(1'b1, 1'b1, last); last = win;
      smp();
      tick(); smp();
      chk("t3_addr", {32'd0, o_mem_addr}, {32'd0, win ? ls_addr : if_addr});
      chk("t3_ready", {62'd0, o_if_req_ready, o_ls_req_ready}, {62'd0, ~win, win});
      tick(); if_req_valid = 1'b0; ls_req_valid = 1'b0; mem_rsp_valid = 1'b1;
      mem_rdata = {$urandom, $urandom};
      smp();
      chk("t3_rsp", {62'd0, o_if_rsp_valid, o_ls_rsp_valid}, {62'd0, ~win, win});
      tick(); mem_rsp_valid = 1'b0;
    end

    // Flush while IF response outstanding: response suppressed, FSM back to idle, drop clears.
    do_reset();
    tick(); if_req_valid = 1'b1; if_addr = 32'h8000_3000; mem_req_ready = 1'b1; smp();
    tick(); smp(); chk("t4_req", {63'd0, o_mem_req_valid}, 64'd1);
    tick(); if_req_valid = 1'b0; if_flush = 1'b1; smp();
    chk("t4_flush_cycle", {63'd0, o_if_rsp_valid}, 64'd0);
    tick(); if_flush = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = {$urandom, $urandom}; smp();
    chk("t4_dropped", {63'd0, o_if_rsp_valid}, 64'd0);
    tick(); mem_rsp_valid = 1'b0; if_req_valid = 1'b1; if_addr = 32'h8000_3004; smp();
    chk("t4_idle_again", {63'd0, o_mem_req_valid}, 64'd0);
    tick(); smp(); chk("t4_req2", {63'd0, o_mem_req_valid}, 64'd1);
    tick(); if_req_valid = 1'b0; if_flush = 1'b1; mem_rsp_valid = 1'b1; smp();
    chk("t4_flush_same_cycle", {63'd0, o_if_rsp_valid}, 64'd0);
    tick(); if_flush = 1'b0; mem_rsp_valid = 1'b0; if_req_valid = 1'b1; if_addr = 32'h8000_3008;
    smp();
    tick(); smp();
    tick(); if_req_valid = 1'b0; mem_rsp_valid = 1'b1; rd = {$urandom, $urandom}; mem_rdata = rd;
    smp();
    chk("t4_drop_cleared", {63'd0, o_if_rsp_valid}, 64'd1);
    chk("t4_inst_lo", {32'd0, o_if_inst}, {32'd0, rd[31:0]});
    tick(); mem_rsp_valid = 1'b0;

    // Back-to-back: IF pending during LSU response; also a flush aimed at an LSU transaction.
    do_reset();
    tick(); ls_req_valid = 1'b1; ls_wen = 1'b0; ls_addr = 32'h8000_5000; ls_wstrb = 8'h0F;
    mem_req_ready = 1'b1; smp();
    tick(); smp();
    chk("t5_load_strb", {55'd0, o_mem_wen, o_mem_wstrb}, 64'd0);
    tick(); ls_req_valid = 1'b0; if_req_valid = 1'b1; if_addr = 32'h8000_400C; if_flush = 1'b1;
    mem_rsp_valid = 1'b1; rd = {$urandom, $urandom}; mem_rdata = rd; smp();
    chk("t5_ls_rsp", {62'd0, o_if_rsp_valid, o_ls_rsp_valid}, 64'd1);
    chk("t5_ls_rdata", o_ls_rdata, rd);
    chk("t5_no_req_yet", {63'd0, o_mem_req_valid}, 64'd0);
    tick(); if_flush = 1'b0; mem_rsp_valid = 1'b0; smp();
    chk("t5_b2b_req", {o_mem_addr, 31'd0, o_mem_req_valid}, {32'h8000_400C, 32'd1});
    tick(); if_req_valid = 1'b0; mem_rsp_valid = 1'b1; rd = {$urandom, $urandom}; mem_rdata = rd;
    smp();
    chk("t5_if_rsp", {63'd0, o_if_rsp_valid}, 64'd1);
    chk("t5_inst_hi", {32'd0, o_if_inst}, {32'd0, rd[63:32]});
    tick(); mem_rsp_valid = 1'b0;

    // Reset asserted mid-response: outputs clear at once, late response ignored.
    do_reset();
    tick(); if_req_valid = 1'b1; if_addr = 32'h8000_6000; mem_req_ready = 1'b1; smp();
    tick(); smp();
    tick(); if_req_valid = 1'b0; smp();
    mem_rsp_valid = 1'b1; mem_rdata = {$urandom, $urandom}; rst_n = 1'b0;
    #1;
    chk("t6_rst_now", {32'd0, o_if_inst}, 64'd0);
    chk("t6_rst_flags", {61'd0, o_mem_req_valid, o_if_rsp_valid, o_ls_rsp_valid}, 64'd0);
    tick(); rst_n = 1'b1; smp();
    chk("t6_late_rsp", {61'd0, o_mem_req_valid, o_if_rsp_valid, o_ls_rsp_valid}, 64'd0);
    tick(); smp();
    chk("t6_late_rsp2", {61'd0, o_mem_req_valid, o_if_rsp_valid, o_ls_rsp_valid}, 64'd0);
    tick(); mem_rsp_valid = 1'b0;

    // Randomized traffic against the transaction-level model.
    do_reset();
    busy = 1'b0; own_ls = 1'b0; acc = 1'b0; dropped = 1'b0; last = 1'b0;
    acc_hi = 1'b0; acc_wen = 1'b0; ifv = 1'b0; lsv = 1'b0;
    ifa = 32'd0; lsa = 32'd0; lswd = 64'd0; lsws = 8'd0; lswen = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (!ifv && $urandom_range(0, 3) == 0) begin
        ifv = 1'b1; ifa = $urandom & 32'hFFFF_FFFC;
      end
      if (!lsv && $urandom_range(0, 3) == 0) begin
        lsv = 1'b1; lsa = $urandom; lswd = {$urandom, $urandom};
        lsws = 8'($urandom); lswen = 1'($urandom);
      end
      if_req_valid = ifv; if_addr = ifv ? ifa : $urandom;
      ls_req_valid = lsv; ls_addr = lsv ? lsa : $urandom;
      ls_wen = lsv ? lswen : 1'($urandom); ls_wdata = lsv ? lswd : {$urandom, $urandom};
      ls_wstrb = lsv ? lsws : 8'($urandom);
      if_flush = ($urandom_range(0, 9) == 0);
      mem_req_ready = 1'($urandom);
      mem_rsp_valid = busy && acc && ($urandom_range(0, 1) == 1);
      mem_rdata = {$urandom, $urandom};
      smp();
      exp_req = busy && !acc;
      chk("r_mem_req", {63'd0, o_mem_req_valid}, {63'd0, exp_req});
      if (exp_req) begin
        chk("r_addr", {32'd0, o_mem_addr}, {32'd0, own_ls ? lsa : ifa});
        chk("r_wen_strb", {55'd0, o_mem_wen, o_mem_wstrb},
            {55'd0, own_ls && lswen, (own_ls && lswen) ? lsws : 8'd0});
        if (own_ls) chk("r_wdata", o_mem_wdata, lswd);
        chk("r_ready", {62'd0, o_if_req_ready, o_ls_req_ready},
            {62'd0, !own_ls && mem_req_ready, own_ls && mem_req_ready});
      end else begin
        chk("r_ready_off", {62'd0, o_if_req_ready, o_ls_req_ready}, 64'd0);
      end
      deliver = busy && acc && mem_rsp_valid;
      chk("r_rsp", {62'd0, o_if_rsp_valid, o_ls_rsp_valid},
          {62'd0, deliver && !own_ls && !dropped && !if_flush, deliver && own_ls});
      if (deliver && !own_ls && !dropped && !if_flush)
        chk("r_inst", {32'd0, o_if_inst}, {32'd0, acc_hi ? mem_rdata[63:32] : mem_rdata[31:0]});
      if (deliver && own_ls)
        chk("r_ls_rdata", o_ls_rdata, acc_wen ? 64'd0 : mem_rdata);
      // Advance the model by one cycle.
      hs = exp_req && mem_req_ready;
      if (busy && !own_ls && if_flush && !deliver) dropped = 1'b1;
      if (hs) begin
        acc = 1'b1;
        if (own_ls) acc_wen = lswen;
        else acc_hi = ifa[2];
      end
      if (deliver || !busy) begin
        if (ifv || lsv) begin
          own_ls = pick(ifv, lsv, last); last = own_ls; busy = 1'b1;
        end else begin
          busy = 1'b0;
        end
        acc = 1'b0; dropped = 1'b0;
      end
      if (hs && !own_ls) ifv = 1'b0;
      if (hs && own_ls) lsv = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
